// File: rtl/hilo_mult_seq.sv
// hilo_mult_seq: sequential 32x32 multiply unit that owns the HI/LO pair.
// Signed operands are reduced to magnitudes, multiplied unsigned by a
// combinational array multiplier that is given MULT_LAT settle cycles,
// then sign-corrected and committed to HI/LO with a DONE pulse.
// MTHI/MTLO write HI/LO directly whenever the unit is idle.
module hilo_mult_seq #(
  parameter int MULT_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MTHI,
  input  logic        MTLO,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    MUL  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Counter reload value; 3 bits covers MULT_LAT up to 8.
  localparam logic [2:0] CNT_LOAD = 3'(MULT_LAT - 1);

  state_t      state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_signed;
  logic        neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [2:0]  cnt;
  logic [63:0] prod_u;
  logic [63:0] raw_prod;

  // Two's-complement magnitude; 0x80000000 maps to itself, a valid unsigned value.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    logic [31:0] m;
    if (sgn && v[31]) begin
      m = ~v + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Full 64-bit negate so the carry ripples from LO into HI; zero stays zero.
  function automatic logic [63:0] sign_fix(input logic [63:0] p, input logic n);
    logic [63:0] r;
    if (n) begin
      r = ~p + 64'd1;
    end else begin
      r = p;
    end
    return r;
  endfunction

  // Unsigned 32x32 array multiplier; its inputs are held stable through MUL.
  always_comb begin
    raw_prod = {32'd0, mag_a} * {32'd0, mag_b};
  end

  // Control FSM with registered BUSY/DONE and the HI/LO architectural state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
      neg       <= 1'b0;
      mag_a     <= 32'd0;
      mag_b     <= 32'd0;
      cnt       <= 3'd0;
      prod_u    <= 64'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (MTHI) begin
            HI <= WDATA;
          end
          if (MTLO) begin
            LO <= WDATA;
          end
          if (START) begin
            op_a      <= A;
            op_b      <= B;
            op_signed <= SIGNED;
            neg       <= SIGNED & (A[31] ^ B[31]);
            BUSY      <= 1'b1;
            state     <= PREP;
          end
        end
        PREP: begin
          DONE  <= 1'b0;
          mag_a <= magnitude(op_a, op_signed);
          mag_b <= magnitude(op_b, op_signed);
          cnt   <= CNT_LOAD;
          state <= MUL;
        end
        MUL: begin
          DONE <= 1'b0;
          if (cnt == 3'd0) begin
            prod_u <= raw_prod;
            state  <= FIX;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        FIX: begin
          {HI, LO} <= sign_fix(prod_u, neg);
          DONE     <= 1'b1;
          BUSY     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_seq.sv
// tb_hilo_mult_seq: table-driven directed checks of hilo_mult_seq plus
// hand-written sequences for the multi-cycle corner cases.
module tb_hilo_mult_seq;

  localparam int LAT = 1;
  localparam int LAT4 = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy4;
  logic        done4;
  logic [31:0] hi4;
  logic [31:0] lo4;

  int checks = 0;
  int errors = 0;

  hilo_mult_seq dut (
    .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .A(a), .B(b),
    .MTHI(mthi), .MTLO(mtlo), .WDATA(wdata),
    .BUSY(busy), .DONE(done), .HI(hi), .LO(lo)
  );

  hilo_mult_seq #(.MULT_LAT(LAT4)) dut4 (
    .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn), .A(a), .B(b),
    .MTHI(mthi), .MTLO(mtlo), .WDATA(wdata),
    .BUSY(busy4), .DONE(done4), .HI(hi4), .LO(lo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply, scramble the operands afterwards, and check timing and result.
  task automatic run_mult(input logic s, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int lat;
    int busy_n;
    sgn = s; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0; a = 32'h1357_9BDF; b = 32'h2468_ACE0; sgn = ~s;
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (busy) busy_n++;
    end
    check({nm, " latency"}, 64'(lat), 64'(2 + LAT));
    check({nm, " busy cycles"}, 64'(busy_n), 64'(2 + LAT));
    check({nm, " busy at done"}, {63'd0, busy}, 64'd0);
    check({nm, " hi"}, {32'd0, hi}, {32'd0, ehi});
    check({nm, " lo"}, {32'd0, lo}, {32'd0, elo});
    tick();
    check({nm, " done width"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int lat;
    int extra;
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
    vecs[7] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFCF};
    vecs[8] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};

    rst = 1'b0; start = 1'b0; sgn = 1'b0; a = 32'd0; b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    tick();
    tick();
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    rst = 1'b1;
    tick();

    // Table: preload HI/LO with a pattern, then multiply and check commit.
    for (int i = 0; i < 10; i++) begin
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      check($sformatf("vec%0d preload hi", i), {32'd0, hi}, 64'h0000_0000_A5A5_A5A5);
      check($sformatf("vec%0d preload lo", i), {32'd0, lo}, 64'h0000_0000_A5A5_A5A5);
      run_mult(vecs[i].s, vecs[i].va, vecs[i].vb, vecs[i].ehi, vecs[i].elo,
               $sformatf("vec%0d", i));
    end

    // START while busy is ignored; no second DONE.
    sgn = 1'b1; a = 32'hFFFF_FFFE; b = 32'h0000_0003; start = 1'b1;
    tick();
    sgn = 1'b0; a = 32'd5; b = 32'd7; start = 1'b1;
    tick();
    check("ign busy", {63'd0, busy}, 64'd1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check("ign latency", 64'(lat), 64'(2 + LAT));
    check("ign hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    check("ign lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) extra++;
    end
    check("ign no second done", 64'(extra), 64'd0);
    check("ign hi hold", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    check("ign lo hold", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);

    // MTHI while idle writes HI only.
    mthi = 1'b1; wdata = 32'h1234_5678;
    tick();
    mthi = 1'b0;
    check("mthi hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    check("mthi lo kept", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);

    // MTLO during MUL is ignored, then product commits.
    mtlo = 1'b1; wdata = 32'h1111_1111;
    tick();
    mtlo = 1'b0;
    sgn = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    mtlo = 1'b0;
    check("mtlo busy lo", {32'd0, lo}, 64'h0000_0000_1111_1111);
    lat = 2;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check("mtlo mul latency", 64'(lat), 64'(2 + LAT));
    check("mtlo mul lo", {32'd0, lo}, 64'd6);

    // MTHI together with START: move lands now, product overwrites at FIX.
    mthi = 1'b1; wdata = 32'h7777_7777;
    sgn = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0002; start = 1'b1;
    tick();
    mthi = 1'b0; start = 1'b0;
    check("mthi+start hi", {32'd0, hi}, 64'h0000_0000_7777_7777);
    lat = 0;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check("mthi+start prod hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    check("mthi+start prod lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);
    tick();

    // Asynchronous reset during MUL discards the multiply.
    sgn = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("rst mul hi", {32'd0, hi}, 64'd0);
    check("rst mul lo", {32'd0, lo}, 64'd0);
    check("rst mul busy", {63'd0, busy}, 64'd0);
    check("rst mul done", {63'd0, done}, 64'd0);
    #3;
    rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) extra++;
    end
    check("rst no commit", 64'(extra), 64'd0);
    check("rst hi stays", {32'd0, hi}, 64'd0);
    run_mult(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, "post rst");

    // MULT_LAT=4 instance: unsigned all-ones case, DONE 6 edges after START.
    repeat (8) tick();
    sgn = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0; a = 32'd0; b = 32'd0;
    lat = 0;
    while (!done4 && lat < 40) begin
      tick();
      lat++;
    end
    check("lat4 latency", 64'(lat), 64'(2 + LAT4));
    check("lat4 busy at done", {63'd0, busy4}, 64'd0);
    check("lat4 hi", {32'd0, hi4}, 64'h0000_0000_FFFF_FFFE);
    check("lat4 lo", {32'd0, lo4}, 64'h0000_0000_0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
